// File: rtl/phase_gen_if.sv
// rtl/phase_gen_if.sv - control/status bundle for the multiphase clock generator
interface phase_gen_if #(
  parameter int PHASES = 2,
  parameter int CW     = 4
);
  logic              i_en;
  logic [CW-1:0]     i_pw;
  logic [CW-1:0]     i_gap;
  logic              i_step_mode;
  logic              i_step;
  logic [PHASES-1:0] o_ph;
  logic              o_s;
  logic [2:0]        o_phase_idx;
  logic              o_busy;

  modport master (
    output i_en, i_pw, i_gap, i_step_mode, i_step,
    input  o_ph, o_s, o_phase_idx, o_busy
  );

  modport slave (
    input  i_en, i_pw, i_gap, i_step_mode, i_step,
    output o_ph, o_s, o_phase_idx, o_busy
  );
endinterface

// File: rtl/phase_gen.sv
// rtl/phase_gen.sv - non-overlapping multiphase clock generator with dead time and single-step
module phase_gen #(
  parameter int PHASES = 2,
  parameter int CW     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  phase_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DEAD   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [2:0]        LAST_IDX = 3'(PHASES - 1);
  localparam logic [CW-1:0]     ONE      = CW'(1);
  localparam logic [PHASES-1:0] PH0      = PHASES'(1);

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_os, w_os_nxt;
  logic          w_do_adv;
  logic          w_do_start;
  logic [CW-1:0] w_pw_load;
  logic [CW-1:0] w_gap_load;

  // Counter reload values; a counter value of N means N+1 remaining cycles,
  // so PW=0 collapses to a one-cycle phase.
  assign w_pw_load  = (bus.i_pw == '0) ? '0 : bus.i_pw - ONE;
  assign w_gap_load = bus.i_gap - ONE;

  // State, phase index, segment counter and cycle-start strobe registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
      r_os    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_os    <= w_os_nxt;
    end
  end

  // Next-state logic; segment ends funnel into a shared advance/start path
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_os_nxt    = 1'b0;
    w_do_adv    = 1'b0;
    w_do_start  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.i_en) w_do_start = 1'b1;
      end
      S_ACTIVE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - ONE;
        end else if (bus.i_gap != '0) begin
          w_state_nxt = S_DEAD;
          w_cnt_nxt   = w_gap_load;
        end else begin
          w_do_adv = 1'b1;
        end
      end
      S_DEAD: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - ONE;
        else             w_do_adv  = 1'b1;
      end
      S_HALT: begin
        if (!bus.i_en)      w_state_nxt = S_IDLE;
        else if (bus.i_step) w_do_start = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // EN is only consulted at the wrap so a dropped EN never truncates a cycle
    if (w_do_adv) begin
      if (r_idx < LAST_IDX) begin
        w_state_nxt = S_ACTIVE;
        w_idx_nxt   = r_idx + 3'd1;
        w_cnt_nxt   = w_pw_load;
      end else if (!bus.i_en) begin
        w_state_nxt = S_IDLE;
      end else if (bus.i_step_mode) begin
        w_state_nxt = S_HALT;
      end else begin
        w_do_start = 1'b1;
      end
    end

    if (w_do_start) begin
      w_state_nxt = S_ACTIVE;
      w_idx_nxt   = 3'd0;
      w_cnt_nxt   = w_pw_load;
      w_os_nxt    = 1'b1;
    end
  end

  assign bus.o_ph        = (r_state == S_ACTIVE) ? (PH0 << r_idx) : '0;
  assign bus.o_s         = r_os;
  assign bus.o_phase_idx = r_idx;
  assign bus.o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_phase_gen.sv
// tb/tb_phase_gen.sv - self-checking bench for phase_gen (PHASES=2 and PHASES=4 instances)
module tb_phase_gen;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] pw = 4'd1;
  logic [3:0] gap = 4'd0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_mode[2];
  int         m_k[2];
  int         m_left[2];
  bit         m_inph[2];
  logic [7:0] e_ph[2];
  logic       e_os[2];

  phase_gen_if #(.PHASES(2), .CW(4)) if2 ();
  phase_gen_if #(.PHASES(4), .CW(4)) if4 ();

  assign if2.i_en = en;  assign if2.i_pw = pw;  assign if2.i_gap = gap;
  assign if2.i_step_mode = step_mode;  assign if2.i_step = step;
  assign if4.i_en = en;  assign if4.i_pw = pw;  assign if4.i_gap = gap;
  assign if4.i_step_mode = step_mode;  assign if4.i_step = step;

  phase_gen #(.PHASES(2), .CW(4)) u_dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2));
  phase_gen #(.PHASES(4), .CW(4)) u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(if4));

  always #5 clk = ~clk;

  // Never more than one phase high, on every cycle of every test
  always @(negedge clk) begin
    n_checks++;
    if ($countones(if2.o_ph) > 1 || $countones(if4.o_ph) > 1) begin
      n_fail++;
      $display("FAIL onehot t=%0t ph2=%b ph4=%b required at most one bit", $time, if2.o_ph, if4.o_ph);
    end
  end

  // Reference model: a segment scheduler. Each segment (phase or dead time)
  // is scheduled at the edge it begins, with its length taken from PW/GAP then.
  task automatic model_reset(input int i);
    m_mode[i] = M_IDLE; m_k[i] = 0; m_left[i] = 0; m_inph[i] = 1'b0;
    e_ph[i] = 8'd0; e_os[i] = 1'b0;
  endtask

  task automatic model_start(input int i, input int len);
    m_mode[i] = M_RUN; m_k[i] = 0; m_inph[i] = 1'b1; m_left[i] = len;
    e_ph[i] = 8'd1; e_os[i] = 1'b1;
  endtask

  task automatic model_step(input int i);
    int n, pwv, gv;
    n   = (i == 0) ? 2 : 4;
    pwv = (pw == 4'd0) ? 1 : int'(pw);
    gv  = int'(gap);
    e_os[i] = 1'b0;
    if (!rst_n) begin
      model_reset(i);
    end else if (m_left[i] > 1) begin
      m_left[i]--;
    end else begin
      m_left[i] = 0;
      case (m_mode[i])
        M_IDLE: if (en) model_start(i, pwv);
        M_HALT: begin
          if (!en) m_mode[i] = M_IDLE;
          else if (step) model_start(i, pwv);
        end
        default: begin
          if (m_inph[i] && gv != 0) begin
            m_inph[i] = 1'b0; m_left[i] = gv; e_ph[i] = 8'd0;
          end else if (m_k[i] < n - 1) begin
            m_k[i]++; m_inph[i] = 1'b1; m_left[i] = pwv; e_ph[i] = 8'(1 << m_k[i]);
          end else if (!en) begin
            m_mode[i] = M_IDLE; e_ph[i] = 8'd0;
          end else if (step_mode) begin
            m_mode[i] = M_HALT; e_ph[i] = 8'd0;
          end else begin
            model_start(i, pwv);
          end
        end
      endcase
    end
  endtask

  function automatic logic [12:0] exp_vec(input int i);
    return {e_ph[i], e_os[i], 3'(m_k[i]), (m_mode[i] != M_IDLE)};
  endfunction

  function automatic logic [12:0] got_vec(input int i);
    if (i == 0) return {6'd0, if2.o_ph, if2.o_s, if2.o_phase_idx, if2.o_busy};
    return {4'd0, if4.o_ph, if4.o_s, if4.o_phase_idx, if4.o_busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; step = 1'b0; step_mode = 1'b0;
    model_reset(0); model_reset(1);
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got_vec(i) !== 13'd0) begin
        n_fail++; $display("FAIL reset dut%0d got=%h required=0", i, got_vec(i));
      end
    end
  endtask

  task automatic test_basic();
    logic [1:0] tbl [4];
    tbl[0] = 2'b01; tbl[1] = 2'b00; tbl[2] = 2'b10; tbl[3] = 2'b00;
    do_reset();
    pw = 4'd1; gap = 4'd1; en = 1'b1;
    for (int t = 0; t < 16; t++) begin
      tick();
      n_checks++;
      if (if2.o_ph !== tbl[t % 4] || if2.o_s !== (t % 4 == 0)) begin
        n_fail++; $display("FAIL basic_pattern t=%0d ph=%b os=%b required ph=%b os=%b", t, if2.o_ph, if2.o_s, tbl[t % 4], (t % 4 == 0));
      end
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_vec(i) !== exp_vec(i)) begin
          n_fail++; $display("FAIL basic dut%0d t=%0d got=%h required=%h", i, t, got_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_pw_gap0();
    do_reset();
    pw = 4'd3; gap = 4'd0; en = 1'b1;
    for (int t = 0; t < 24; t++) begin
      tick();
      n_checks++;
      if (if4.o_ph !== 4'(1 << ((t / 3) % 4)) || if4.o_s !== (t % 12 == 0)) begin
        n_fail++; $display("FAIL pw3_period t=%0d ph=%b os=%b required ph=%b os=%b", t, if4.o_ph, if4.o_s, 4'(1 << ((t / 3) % 4)), (t % 12 == 0));
      end
    end
    do_reset();
    pw = 4'd0; en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      n_checks++;
      if (if4.o_ph !== 4'(1 << (t % 4))) begin
        n_fail++; $display("FAIL pw0 t=%0d ph=%b required=%b", t, if4.o_ph, 4'(1 << (t % 4)));
      end
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_vec(i) !== exp_vec(i)) begin
          n_fail++; $display("FAIL pw0_model dut%0d t=%0d got=%h required=%h", i, t, got_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_en_drop();
    logic [1:0] tph [8];
    logic       tbz [8];
    tph[0] = 2'b01; tph[1] = 2'b01; tph[2] = 2'b00; tph[3] = 2'b10;
    tph[4] = 2'b10; tph[5] = 2'b00; tph[6] = 2'b00; tph[7] = 2'b00;
    for (int t = 0; t < 8; t++) tbz[t] = (t < 6);
    do_reset();
    pw = 4'd2; gap = 4'd1; en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (t == 0) en = 1'b0;
      n_checks++;
      if (if2.o_ph !== tph[t] || if2.o_busy !== tbz[t]) begin
        n_fail++; $display("FAIL en_drop t=%0d ph=%b busy=%b required ph=%b busy=%b", t, if2.o_ph, if2.o_busy, tph[t], tbz[t]);
      end
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_vec(i) !== exp_vec(i)) begin
          n_fail++; $display("FAIL en_drop_model dut%0d t=%0d got=%h required=%h", i, t, got_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_step();
    do_reset();
    pw = 4'd1; gap = 4'd0; en = 1'b1; step_mode = 1'b1; step = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (t == 1) step = 1'b0;
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_vec(i) !== exp_vec(i)) begin
          n_fail++; $display("FAIL step_model dut%0d t=%0d got=%h required=%h", i, t, got_vec(i), exp_vec(i));
        end
      end
    end
    n_checks++;
    if (if2.o_ph !== 2'b00 || if2.o_busy !== 1'b1) begin
      n_fail++; $display("FAIL halt ph=%b busy=%b required ph=00 busy=1", if2.o_ph, if2.o_busy);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    n_checks++;
    if (if2.o_ph !== 2'b01 || if2.o_s !== 1'b1) begin
      n_fail++; $display("FAIL step_go ph=%b os=%b required ph=01 os=1", if2.o_ph, if2.o_s);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pw = 4'd3; gap = 4'd0; en = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    n_checks++;
    if (if2.o_ph !== 2'b10) begin
      n_fail++; $display("FAIL pre_reset ph=%b required=10", if2.o_ph);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got_vec(i) !== 13'd0) begin
        n_fail++; $display("FAIL async_reset dut%0d got=%h required=0", i, got_vec(i));
      end
    end
    model_reset(0); model_reset(1);
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got_vec(i) !== 13'h0105 >> 0 && got_vec(i) !== exp_vec(i)) begin
        n_fail++; $display("FAIL restart dut%0d got=%h required=%h", i, got_vec(i), exp_vec(i));
      end
    end
    n_checks++;
    if (if2.o_ph !== 2'b01 || if2.o_s !== 1'b1 || if4.o_ph !== 4'b0001) begin
      n_fail++; $display("FAIL restart_ph ph2=%b os=%b ph4=%b required 01 1 0001", if2.o_ph, if2.o_s, if4.o_ph);
    end
  endtask

  task automatic test_pw_change();
    logic [1:0] tph [8];
    tph[0] = 2'b01; tph[1] = 2'b01;
    for (int t = 2; t < 7; t++) tph[t] = 2'b10;
    tph[7] = 2'b01;
    do_reset();
    pw = 4'd2; gap = 4'd0; en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (t == 0) pw = 4'd5;
      n_checks++;
      if (if2.o_ph !== tph[t]) begin
        n_fail++; $display("FAIL pw_change t=%0d ph=%b required=%b", t, if2.o_ph, tph[t]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 600; t++) begin
      en   = ($urandom_range(0, 7) != 0);
      pw   = 4'($urandom_range(0, 3));
      gap  = 4'($urandom_range(0, 2));
      step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
      tick();
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (got_vec(i) !== exp_vec(i)) begin
          n_fail++; $display("FAIL random dut%0d t=%0d got=%h required=%h", i, t, got_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    model_reset(0); model_reset(1);
    test_reset();
    test_basic();
    test_pw_gap0();
    test_en_drop();
    test_step();
    test_async_reset();
    test_pw_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_gen.md
PHASE_GEN -- requirements
Module: phase_gen

Interface
REQ-001: Parameter PHASES, default 2: number of non-overlapping phase outputs, legal range 2..8.
REQ-002: Parameter CW, default 4: width of the runtime phase-width and gap counters, legal range 2..8.
REQ-003: CLK  input  1  single system clock; all state changes occur on its rising edge.
REQ-004: RST  input  1  asynchronous, active-low reset; RST=0 forces reset state immediately, independent of CLK.
REQ-005: EN  input  1  run enable, sampled on CLK.
REQ-006: PW  input  CW  phase high-time in CLK cycles; 0 is treated as 1.
REQ-007: GAP  input  CW  dead time in CLK cycles after each phase; 0 means no dead time.
REQ-008: STEP_MODE  input  1  1 = halt after each full cycle until STEP.
REQ-009: STEP  input  1  in HALT, a 1 starts the next full cycle.
REQ-010: PH  output  PHASES  phase clocks; one-hot or all-zero, registered.
REQ-011: O_S  output  1  one-cycle cycle-start strobe, registered.
REQ-012: PHASE_IDX  output  3  index of the current or last-driven phase.
REQ-013: BUSY  output  1  1 whenever state is not IDLE.

Function
REQ-014: FSM states: IDLE, ACTIVE, DEAD, HALT; state, index and counter are registered; PH, O_S and BUSY decode directly from registered state.
REQ-015: PH SHALL never have more than one bit set in any cycle; PH is all-zero in IDLE, DEAD and HALT.
REQ-016: IDLE: EN=1 -> ACTIVE with idx=0, cnt=max(PW,1)-1; PH[0] and O_S rise at that edge, so latency is one edge.
REQ-017: ACTIVE: PH[idx]=1; cnt decrements each cycle; at cnt=0 -> DEAD with cnt=GAP-1 if GAP!=0, otherwise advance directly (REQ-019).
REQ-018: DEAD: cnt decrements; at cnt=0 advance (REQ-019).
REQ-019: Advance when idx<PHASES-1 -> ACTIVE, idx+1, cnt reloaded from PW.
REQ-020: Advance when idx=PHASES-1 (wrap):
- EN=0 -> IDLE.
- else STEP_MODE=1 -> HALT.
- else ACTIVE, idx=0, O_S pulse.
REQ-021: HALT: EN=0 -> IDLE; else STEP=1 -> ACTIVE, idx=0, O_S pulse; else remain in HALT. STEP outside HALT is ignored.
REQ-022: PW and GAP are sampled only when a segment's counter is loaded; changes mid-segment take effect at the next segment.
REQ-023: EN=0 mid-cycle SHALL NOT truncate pulses; the current full cycle completes, including the final dead time, then the FSM enters IDLE.
REQ-024: Full period with STEP_MODE=0 is PHASES*(max(PW,1)+GAP) cycles; O_S asserts exactly once per period, coincident with the first cycle of PH[0].
REQ-025: Back-to-back cycles have no idle cycle between the last dead time and the next PH[0].

Reset
REQ-026: When RST=0, state=IDLE, idx=0, cnt=0 and PH=0, O_S=0, PHASE_IDX=0, BUSY=0, asynchronously and mid-operation included.
REQ-027: After RST rises, the first start occurs at the first CLK edge with EN=1; if EN is already 1, PH[0] rises at the first edge after release.

Verification
REQ-028: PHASES=2, PW=1, GAP=1, EN=1 -> PH repeats 01,00,10,00; O_S=1 every 4th cycle with PH=01.
REQ-029: PHASES=4, PW=3, GAP=0 -> each PH bit high for 3 cycles, 12-cycle period, never two bits set; PW=0 gives 1-cycle phases.
REQ-030: PHASES=2, PW=2, GAP=1, EN dropped during PH[0] -> PH[0] for 2 cycles, dead, PH[1] for 2 cycles, dead, then IDLE with BUSY=0; no runt pulses.
REQ-031: STEP_MODE=1 -> one full cycle, then HALT with PH=0 and BUSY=1; STEP pulse -> PH[0] and O_S on the next edge; STEP held during ACTIVE has no effect.
REQ-032: RST=0 asserted asynchronously during PH[1] -> all outputs 0 before the next CLK edge; on release with EN=1, restart at PH[0] with O_S=1.
REQ-033: Change PW from 2 to 5 mid-phase -> the current phase keeps 2 cycles and the next phase lasts 5; a checker asserts one-hot PH on every cycle of all tests.
